// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared constants and helper functions for the mem_pipe buffer.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int INIT_ZERO = 0;
    localparam int INIT_ADDR = 1;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Two extra slots keep the FIFO from ever blocking a full-rate stream.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_pipe_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_pipe_fifo
// Brief    : Show-ahead FIFO; head word is presented whenever valid is high.
// Revision : 1.0
// ============================================================================
module mem_pipe_fifo
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_do_pop;

    assign w_do_pop = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_ONE;
            end
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid = (r_count != '0);
    assign data  = valid ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

    // Upstream credit accounting guarantees space; a push into a full FIFO is a bug.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && (r_count == FULL_COUNT) && !pop))
        else $error("mem_pipe_fifo: push into full FIFO");

endmodule
`default_nettype wire

// File: rtl/mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_pipe
// Brief    : Simple-dual-port byte-enable memory with pipelined, credit-based
//            valid/ready read path. Optional macro: MEM_PIPE_STATS_EN.
// Revision : 1.0
// ============================================================================
module mem_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_ADDRESSES   = 65536,
    parameter int LOG_MAX_ADDRESS = 16,
    parameter int BYTE_WIDTH      = 8,
    parameter int READ_LATENCY    = 2,
    parameter int WRITE_FIRST     = 1,
    parameter int INIT_MODE       = 1,
    localparam int NBE            = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_write,
    input  logic [LOG_MAX_ADDRESS-1:0] addr_write,
    input  logic                       write,
    input  logic [NBE-1:0]             write_be,
    input  logic [LOG_MAX_ADDRESS-1:0] addr_read,
    input  logic                       read,
    output logic                       read_ready,
    output logic [DATA_WIDTH-1:0]      data_read,
    output logic                       valid_out,
    input  logic                       ready_out
);

    localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int CNT_WIDTH  = clog2(FIFO_DEPTH + 1);
    localparam logic [LOG_MAX_ADDRESS:0] ADDR_LIMIT = (LOG_MAX_ADDRESS + 1)'(NUM_ADDRESSES);
    localparam logic [CNT_WIDTH:0]       CREDIT_LIMIT = (CNT_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [NUM_ADDRESSES] = '{default: '0};

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_en;
    logic                  w_accept;
    logic                  w_collision;
    logic [DATA_WIDTH-1:0] w_wr_key;
    logic [DATA_WIDTH-1:0] w_rd_key;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pipe_valid;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_pop;
    logic [CNT_WIDTH-1:0]  r_inflight;
    logic [CNT_WIDTH-1:0]  w_fifo_count;

    assign w_wr_in_range = ({1'b0, addr_write} < ADDR_LIMIT);
    assign w_rd_in_range = ({1'b0, addr_read}  < ADDR_LIMIT);
    assign w_wr_en       = write && !rst && w_wr_in_range;
    assign w_accept      = read && read_ready;
    assign w_collision   = w_accept && w_wr_en && w_rd_in_range && (addr_read == addr_write);

    // The array powers up zeroed; address-initialised contents are obtained by
    // storing each word XOR its address, so mem[i] reads back as i until written.
    generate
        if (INIT_MODE == INIT_ADDR) begin : g_init_addr
            assign w_wr_key = DATA_WIDTH'(addr_write);
            assign w_rd_key = DATA_WIDTH'(addr_read);
        end else begin : g_init_zero
            assign w_wr_key = '0;
            assign w_rd_key = '0;
        end
    endgenerate

    assign w_wr_word  = data_write ^ w_wr_key;
    assign w_old_word = w_rd_in_range ? (r_mem[addr_read] ^ w_rd_key) : '0;

    always_comb begin
        w_merged = w_old_word;
        for (int k = 0; k < NBE; k++) begin
            if (write_be[k]) begin
                w_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = data_write[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign w_rd_word = ((WRITE_FIRST == RDW_WRITE_FIRST) && w_collision) ? w_merged : w_old_word;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < NBE; k++) begin
                if (write_be[k]) begin
                    r_mem[addr_write][k*BYTE_WIDTH +: BYTE_WIDTH] <= w_wr_word[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage 0 is the RAM output register; later stages only retime the word.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pipe_data[0] <= w_rd_word;
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
            r_pipe_data[s] <= r_pipe_data[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= w_accept;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_valid[s] <= r_pipe_valid[s-1];
            end
        end
    end

    assign w_push      = r_pipe_valid[READ_LATENCY-1];
    assign w_push_data = r_pipe_data[READ_LATENCY-1];
    assign w_pop       = valid_out && ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + CNT_ONE;
                2'b01:   r_inflight <= r_inflight - CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Same-cycle pops are deliberately not credited back.
    assign read_ready = (({1'b0, r_inflight} + {1'b0, w_fifo_count}) < CREDIT_LIMIT);

    mem_pipe_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (w_pop),
        .data       (data_read),
        .valid      (valid_out),
        .count      (w_fifo_count)
    );

`ifdef MEM_PIPE_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_collisions;
    logic [31:0] r_stat_stalls;
    logic [31:0] r_stat_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_reads      <= '0;
            r_stat_writes     <= '0;
            r_stat_collisions <= '0;
            r_stat_stalls     <= '0;
            r_stat_cycle      <= '0;
        end else begin
            r_stat_cycle <= r_stat_cycle + 32'd1;
            if (w_accept && (r_stat_reads != '1)) begin
                r_stat_reads <= r_stat_reads + 32'd1;
            end
            if (w_wr_en && (r_stat_writes != '1)) begin
                r_stat_writes <= r_stat_writes + 32'd1;
            end
            if (w_collision && (r_stat_collisions != '1)) begin
                r_stat_collisions <= r_stat_collisions + 32'd1;
            end
            if (valid_out && !ready_out && (r_stat_stalls != '1)) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
            if (w_collision) begin
                $display("mem_pipe: collision cycle %0d addr 0x%0h policy %s", r_stat_cycle,
                         addr_read, (WRITE_FIRST == RDW_WRITE_FIRST) ? "write-first" : "read-first");
            end
        end
    end
`endif

endmodule
`default_nettype wire
